// File: rtl/m_fetch_pkg.sv
// Shared types and constants for the IF-stage fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package m_fetch_pkg;

    // REQ issues the memory strobe, WAIT awaits the response, HOLD presents it to IF/ID.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // All-zero word shown to IF/ID whenever no fetched instruction is available.
    localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/m_pc_reg.sv
// Program counter register with sequential advance, redirect mux and +4 adder.
// Latency: new PC visible one cycle after advance_i/redirect_i; pcplus4_o is combinational.
// Backpressure: holds its value whenever neither advance_i nor redirect_i is set.
module m_pc_reg
    import m_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pcplus4_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Wraps modulo 2^XLEN; no carry out is kept.
    assign pcplus4_o = pc_q + XLEN'(4);
    assign pc_o      = pc_q;

    // Redirect beats sequential advance; redirect targets are forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & ~XLEN'(3);
        end else if (advance_i) begin
            pc_d = pcplus4_o;
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/m_fetch_unit.sv
// IF-stage producer: fetches one instruction at a time over imem req/rvalid and feeds IF/ID.
// Latency: req -> response -> HOLD; 3 cycles per instruction with 1-cycle memory.
// Backpressure: stallF freezes HOLD; pcsrcD redirects and kills stale responses. FETCH_MISALIGN_CHK_EN adds a sticky misalign flag.
module m_fetch_unit
    import m_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallF,
    input  logic            pcsrcD,
    input  logic [XLEN-1:0] pcbranchD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pcplus4,
    output logic            fetch_valid,
    output logic            misalign
);

    fetch_state_t    state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] instr_buf_q, instr_buf_d;
    logic            pc_advance;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    m_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance_i  (pc_advance),
        .redirect_i (pcsrcD),
        .target_i   (pcbranchD),
        .pc_o       (pc),
        .pcplus4_o  (pc_plus4)
    );

    // Next-state logic; a redirect always wins over stallF and over a live response.
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        instr_buf_d = instr_buf_q;
        pc_advance  = 1'b0;
        case (state_q)
            REQ: begin
                // The strobe already went out at the old PC; a redirect now marks its data stale.
                state_d = WAIT;
                kill_d  = pcsrcD;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || pcsrcD) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_buf_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end else if (pcsrcD) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (pcsrcD) begin
                    state_d = REQ;
                end else if (!stallF) begin
                    pc_advance = 1'b1;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // Control and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REQ;
            kill_q      <= 1'b0;
            instr_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            instr_buf_q <= instr_buf_d;
        end
    end

    // The reset state is REQ, so the strobe is gated to keep it quiet while rst_n is low.
    assign imem_req    = rst_n && (state_q == REQ);
    assign imem_addr   = imem_req ? pc : '0;
    assign fetch_valid = (state_q == HOLD);
    assign instr       = fetch_valid ? instr_buf_q : XLEN'(BUBBLE_INSTR);
    assign pcplus4     = fetch_valid ? pc_plus4 : '0;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    // Sticky until reset: any redirect whose low address bits are non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (pcsrcD && (pcbranchD[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_m_fetch_unit.sv
// Bench for m_fetch_unit: directed scenarios followed by random stall/redirect/latency traffic.
// Latency: memory responds 1..4 cycles after each request.
// Backpressure: stallF and pcsrcD driven by the bench.
module tb_m_fetch_unit;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallF;
    logic        pcsrcD;
    logic [31:0] pcbranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        fetch_valid;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    // Memory environment
    logic        mem_busy;
    int          mem_cnt;
    int          mem_lat;
    logic [31:0] mem_addr;
    logic        ovr_en;
    logic [31:0] ovr_dat;

    // Reference model: what has been requested, what is held, where fetching continues.
    logic        m_req_due;
    logic [31:0] m_next_pc;
    logic        m_out;
    logic [31:0] m_out_addr;
    logic        m_stale;
    logic        m_held;
    logic [31:0] m_held_addr;
    logic [31:0] m_held_dat;
    logic        m_mis;

    m_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stallF      (stallF),
        .pcsrcD      (pcsrcD),
        .pcbranchD   (pcbranchD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pcplus4     (pcplus4),
        .fetch_valid (fetch_valid),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic s, input logic r, input logic [31:0] tgt);
        stallF    = s;
        pcsrcD    = r;
        pcbranchD = tgt;
        if (mem_busy && mem_cnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ovr_en ? ovr_dat : mem_word(mem_addr);
            mem_busy    = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_busy) mem_cnt--;
        end
        #1;
        chk("req", {31'b0, imem_req}, {31'b0, m_req_due});
        if (m_req_due) chk("addr", imem_addr, m_next_pc);
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_held});
        chk("instr", instr, m_held ? m_held_dat : 32'h0);
        chk("pcplus4", pcplus4, m_held ? m_held_addr + 32'd4 : 32'h0);
        chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
        if (imem_req) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
        end
        if (m_req_due) begin
            m_req_due  = 1'b0;
            m_out      = 1'b1;
            m_out_addr = m_next_pc;
            m_stale    = 1'b0;
        end else if (m_out && imem_rvalid) begin
            m_out = 1'b0;
            if (m_stale || r) begin
                m_req_due = 1'b1;
            end else begin
                m_held      = 1'b1;
                m_held_addr = m_out_addr;
                m_held_dat  = imem_rdata;
            end
        end else if (m_held) begin
            if (r) begin
                m_held    = 1'b0;
                m_req_due = 1'b1;
            end else if (!s) begin
                m_held    = 1'b0;
                m_req_due = 1'b1;
                m_next_pc = m_held_addr + 32'd4;
            end
        end
        if (r) begin
            m_next_pc = {tgt[31:2], 2'b00};
            if (m_out) m_stale = 1'b1;
            if (EXP_MIS && tgt[1:0] != 2'b00) m_mis = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stallF = 1'b0; pcsrcD = 1'b0; pcbranchD = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; mem_addr = '0;
        ovr_en = 1'b0; ovr_dat = '0;
        m_req_due = 1'b1; m_next_pc = '0; m_out = 1'b0; m_out_addr = '0; m_stale = 1'b0;
        m_held = 1'b0; m_held_addr = '0; m_held_dat = '0; m_mis = 1'b0;

        // Reset: every output quiet
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pcplus4", pcplus4, 32'h0);
        chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // First fetch after reset with 1-cycle memory
        chk("c0_req", {31'b0, imem_req}, 32'h1);
        chk("c0_addr", imem_addr, 32'h0);
        ovr_en = 1'b1; ovr_dat = 32'h0050_0093;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        ovr_en = 1'b0;
        chk("c2_valid", {31'b0, fetch_valid}, 32'h1);
        chk("c2_instr", instr, 32'h0050_0093);
        chk("c2_pcplus4", pcplus4, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        chk("c3_req", {31'b0, imem_req}, 32'h1);
        chk("c3_addr", imem_addr, 32'h4);

        // Stall for 4 cycles in HOLD
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_req", {31'b0, imem_req}, 32'h0);
            chk("stall_instr", instr, mem_word(32'h4));
            chk("stall_pcplus4", pcplus4, 32'h8);
            step(1'b1, 1'b0, 32'h0);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("post_stall_addr", imem_addr, 32'h8);

        // Redirect during WAIT, late stale response dropped
        mem_lat = 3;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        ovr_en = 1'b1; ovr_dat = 32'hDEAD_BEEF;
        step(1'b0, 1'b0, 32'h0);
        ovr_en = 1'b0; mem_lat = 1;
        chk("kill_valid", {31'b0, fetch_valid}, 32'h0);
        chk("kill_req", {31'b0, imem_req}, 32'h1);
        chk("kill_addr", imem_addr, 32'h100);

        // Redirect together with stall in HOLD
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("hold_pcplus4", pcplus4, 32'h104);
        step(1'b1, 1'b1, 32'h100);
        chk("redir_hold_req", {31'b0, imem_req}, 32'h1);
        chk("redir_hold_addr", imem_addr, 32'h100);

        // Redirect in REQ to the top word, then wrap-around
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_pcplus4", pcplus4, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Misaligned redirect, coinciding with a response
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h102);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_flag", {31'b0, misalign}, {31'b0, EXP_MIS});
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("mis_sticky", {31'b0, misalign}, {31'b0, EXP_MIS});

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            mem_lat = $urandom_range(1, 4);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_fetch_unit.md
Name: m_fetch_unit

Overview:
- IF-stage producer for the IF/ID pipeline register: holds the PC and fetches from instruction memory through a req/rvalid handshake.
- Drives instr/pcplus4 into the IF/ID register and emits an all-zero bubble while no fetched instruction is available.
- Obeys the hazard unit's stallF and the ID-stage branch redirect (pcsrcD, pcbranchD).
- Single outstanding memory request; responses made stale by a redirect are discarded.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stallF  in  1  hold the current instruction and PC
- pcsrcD  in  1  redirect request from ID (branch/jump taken)
- pcbranchD  in  XLEN  redirect target
- imem_req  out  1  one-cycle fetch request strobe
- imem_addr  out  XLEN  fetch address, valid while imem_req=1
- imem_rvalid  in  1  response valid, at least 1 cycle after imem_req
- imem_rdata  in  XLEN  response instruction word
- instr  out  XLEN  instruction to the IF/ID register (0 = bubble)
- pcplus4  out  XLEN  PC+4 of instr (0 with a bubble)
- fetch_valid  out  1  instr/pcplus4 carry a real instruction
- misalign  out  1  sticky misaligned-redirect flag (optional feature)

Behaviour:
- Reset, asynchronous on rst_n=0:
  - pc=RESET_PC, state=REQ, kill=0, instr_buf=0, misalign=0.
  - All outputs 0 while in reset.
- States: REQ, WAIT, HOLD.
- REQ:
  - imem_req=1, imem_addr=pc; next state WAIT.
  - Exactly one cycle per request.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with kill=1: drop the data, clear kill, go to REQ.
  - On imem_rvalid with kill=0: instr_buf<=imem_rdata, go to HOLD.
- HOLD:
  - instr=instr_buf, pcplus4=pc+4, fetch_valid=1.
  - If stallF=0: the IF/ID register consumes the instruction this cycle; pc<=pc+4; go to REQ.
  - If stallF=1: stay in HOLD; outputs stable.
- Outside HOLD: instr=0, pcplus4=0, fetch_valid=0. All three are combinational from state and registers.
- Redirect (pcsrcD=1) has priority over stallF in every state:
  - REQ: the request still issues at the old pc; pc<=pcbranchD; kill<=1; go to WAIT.
  - WAIT, no rvalid: pc<=pcbranchD; kill<=1; stay in WAIT.
  - WAIT with rvalid in the same cycle: drop the data; pc<=pcbranchD; kill<=0; go to REQ.
  - HOLD: drop instr_buf; pc<=pcbranchD; go to REQ. The outputs in that cycle still show HOLD contents, and the IF/ID register flushes them.
  - A second redirect while kill=1 only updates pc.
- Arithmetic:
  - pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC gives pcplus4=0 and next pc=0).
  - No other width extension.
- Throughput: one instruction per 3 cycles with 1-cycle memory latency. Memory latency adds to WAIT time one-for-one.
- imem_rvalid outside WAIT is a protocol error; it is ignored.

Optional Feature:
- Macro FETCH_MISALIGN_CHK_EN.
- Defined:
  - A redirect with pcbranchD[1:0]!=0 sets misalign=1, sticky until reset.
  - The PC loads {pcbranchD[XLEN-1:2],2'b00}.
- Undefined:
  - misalign is tied to 0.
  - The PC still loads {pcbranchD[XLEN-1:2],2'b00}, with no indication.

Decomposition:
- Package m_fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, HOLD}
  - BUBBLE_INSTR = 32'h0
  - DEFAULT_RESET_PC
- Sub-module m_pc_reg: PC flop with async reset, load-enable and redirect mux, plus the +4 adder output.

Test Plan:
- Reset release with 1-cycle memory returning 32'h00500093 at address 0 → imem_req at cycle 0 with addr 0; HOLD at cycle 2 with instr=32'h00500093, pcplus4=4; next request at addr 4 at cycle 3.
- stallF=1 for 4 cycles during HOLD → instr/pcplus4 stable, no imem_req; after release the request goes to pc+4.
- pcsrcD=1, pcbranchD=32'h100 during WAIT; late rvalid with 32'hDEADBEEF → data dropped, fetch_valid stays 0; next request at addr 32'h100.
- pcsrcD=1 together with stallF=1 in HOLD → redirect wins; next state REQ with addr 32'h100.
- pc=32'hFFFF_FFFC fetched → pcplus4=0; next imem_addr=0.
- FETCH_MISALIGN_CHK_EN defined, redirect to 32'h102 → misalign=1 (sticky), imem_addr=32'h100; macro undefined → misalign stays 0.
